mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed memory target that answers processor fetch, load and store requests over a valid/ready request channel and a valid/ready response channel.
- Sits between the multi-cycle processor core (initiator) and the main memory array, replacing the core's direct array indexing.
- Supports up to DEPTH outstanding requests.
- Responses are returned strictly in request order after a fixed pipeline latency.

Parameters:
- LATENCY, 2: cycles from request acceptance to earliest rsp_valid; legal 1..8.
- DEPTH, 4: maximum requests outstanding (in pipeline plus response queue); legal 2..16.
- MEM_WORDS, 4096: number of 16-bit words in the array; power of two, at most 65536.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; block is in reset while reset==0.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load/fetch.
- req_addr  input  16  word address.
- req_wdata  input  16  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator consumes the response.
- rsp_write  output  1  echo of req_write for this response.
- rsp_rdata  output  16  load data, or the written data echoed for a store.
- busy  output  1  at least one request outstanding.

Behaviour:
- Reset (reset==0, asynchronous):
  - Pipeline valid bits, response queue pointers and outstanding count clear immediately.
  - req_ready=0 while in reset; req_ready=1 from the first clock after reset deasserts.
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0.
  - Array contents are not cleared.
- Reset mid-operation: all in-flight and queued responses are discarded and never presented. Stores already accepted remain committed.
- Accept: on a cycle where req_valid && req_ready.
- Credit rule: req_ready = (outstanding < DEPTH). The count increments on accept, decrements on a response handshake (rsp_valid && rsp_ready), and is unchanged when both occur in the same cycle. At outstanding==DEPTH, a same-cycle pop does not raise req_ready in that cycle; req_ready is a registered function of the count.
- Store: commits to the array at the accept edge.
- Load: samples the array at the accept edge, after any store accepted in an earlier cycle. A load to an address stored in the previous cycle returns the new data. No same-cycle read/write hazard exists because only one request is accepted per cycle.
- Addressing: index = req_addr modulo MEM_WORDS; upper bits are ignored (see Optional Feature).
- Pipeline: LATENCY-stage shift register carrying {valid, write, data}. A stage exiting the pipeline enters the response queue (DEPTH entries, circular, wrap-around at DEPTH). The credit rule guarantees no overflow.
- Latency: a request accepted at edge N, with an empty queue, drives rsp_valid=1 after edge N+LATENCY.
- Back-to-back requests produce back-to-back responses (one per cycle) while rsp_ready=1.
- Response channel:
  - rsp_valid reflects a non-empty queue; the head is presented on rsp_write/rsp_rdata.
  - Payload is held stable while rsp_valid && !rsp_ready.
  - Pop on handshake.
  - When the queue is empty, rsp_rdata holds its last value.
- Ordering: responses are in strict acceptance order; stores and loads are never reordered.
- busy = (outstanding != 0).
- req_* inputs are ignored when req_ready==0. No error for req_valid dropping without handshake.

Optional Feature:
- Macro: MEM_RESPONDER_ERR_EN
- Defined:
  - Adds output port rsp_err (1 bit, reset 0), carried alongside each response.
  - A request with req_addr >= MEM_WORDS is out of range: a store is dropped (array unchanged), a load returns 0, and the response carries rsp_err=1.
  - In-range requests carry rsp_err=0.
- Undefined: no rsp_err port; addresses wrap modulo MEM_WORDS as above.

Test Plan:
- Reset then store addr 0x0010 data 0xBEEF, then load 0x0010 next cycle, rsp_ready=1 -> two responses at accept+LATENCY in order: (write=1, 0xBEEF) then (write=0, 0xBEEF).
- rsp_ready=0, issue 6 loads with DEPTH=4 -> exactly 4 accepted; req_ready=0 thereafter. Raise rsp_ready -> 4 responses in address order, then req_ready returns to 1, busy falls to 0 after the last pop.
- Stall mid-burst: rsp_ready toggles 1,0,0,1 -> rsp_rdata/rsp_write held stable during the low cycles; no response lost or duplicated.
- Assert reset=0 with 3 requests outstanding -> rsp_valid=0 and busy=0 immediately. After release, a load of a previously stored address returns the stored value, and no stale response appears.
- Wrap: with MEM_WORDS=4096 and MEM_RESPONDER_ERR_EN undefined, store 0x1234 to 0x1005 then load 0x0005 -> 0x1234. With the macro defined, the same store gives rsp_err=1 and the load of 0x0005 returns the prior contents.
- Streaming: 20 alternating store/load requests with req_valid and rsp_ready held at 1 -> one response per cycle after the initial LATENCY, req_ready never deasserts.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response channel bundle between the processor core and mem_responder.
// rsp_err exists only when MEM_RESPONDER_ERR_EN is defined.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        busy;
`ifdef MEM_RESPONDER_ERR_EN
    logic        rsp_err;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy
`ifdef MEM_RESPONDER_ERR_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, busy
`ifdef MEM_RESPONDER_ERR_EN
        , output rsp_err
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target: credit-limited request intake, fixed-latency pipeline, in-order response queue.
// Define MEM_RESPONDER_ERR_EN to flag (and suppress) accesses with req_addr >= MEM_WORDS via rsp_err.
module mem_responder #(
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 4096
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic        write;
`ifdef MEM_RESPONDER_ERR_EN
        logic        err;
`endif
        logic [15:0] data;
    } rsp_t;

    logic [15:0]        mem [MEM_WORDS];
    rsp_t               q_buf [DEPTH];

    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    rsp_t               pipe_q [LATENCY];
    rsp_t               pipe_d [LATENCY];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      q_cnt_q, q_cnt_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    rsp_t               last_q, last_d;

    logic               rsp_vld;
    logic               accept;
    logic               pop;
    logic               push;
    logic               mem_we;
    rsp_t               req_rsp;
    rsp_t               head;
    logic [AW-1:0]      idx;
`ifdef MEM_RESPONDER_ERR_EN
    logic               oor;
`endif

    // Upper address bits only matter for the range check; plain builds wrap.
    assign idx = bus.req_addr[AW-1:0];
    generate
        if (AW < 16) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.req_addr[15:AW];
        end
    endgenerate

`ifdef MEM_RESPONDER_ERR_EN
    assign oor = ({1'b0, bus.req_addr} >= 17'(MEM_WORDS));
`endif

    assign rsp_vld = (q_cnt_q != '0);

    always_comb begin
        accept      = bus.req_valid && req_ready_q;
        pop         = rsp_vld && bus.rsp_ready;
        push        = vld_pipe_q[LATENCY-1];

        // Loads capture the array before this edge's write; a store to the same
        // address can only have been accepted in an earlier cycle.
        req_rsp       = '0;
        req_rsp.write = bus.req_write;
        req_rsp.data  = bus.req_write ? bus.req_wdata : mem[idx];
        mem_we        = accept && bus.req_write;
`ifdef MEM_RESPONDER_ERR_EN
        req_rsp.err   = oor;
        if (oor && !bus.req_write) req_rsp.data = '0;
        mem_we        = accept && bus.req_write && !oor;
`endif

        vld_pipe_d    = '0;
        vld_pipe_d[0] = accept;
        pipe_d[0]     = req_rsp;
        for (int i = 1; i < LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            pipe_d[i]     = pipe_q[i-1];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        q_cnt_d  = q_cnt_q + CW'(push) - CW'(pop);

        // Credits cover pipeline plus queue, so the queue can never overflow.
        cnt_d       = cnt_q + CW'(accept) - CW'(pop);
        req_ready_d = (cnt_d < CW'(DEPTH));

        head   = rsp_vld ? q_buf[rd_ptr_q] : last_q;
        last_d = head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            q_cnt_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            last_q      <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            q_cnt_q     <= q_cnt_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            last_q      <= last_d;
        end
    end

    // Storage and payload registers: contents survive reset, validity does not.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= bus.req_wdata;
        if (push)   q_buf[wr_ptr_q] <= pipe_q[LATENCY-1];
        for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_write = head.write;
    assign bus.rsp_rdata = head.data;
    assign bus.busy      = (cnt_q != '0);
`ifdef MEM_RESPONDER_ERR_EN
    assign bus.rsp_err   = head.err;
`endif

    a_credit_bound: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CW'(DEPTH));
    a_no_overflow:  assert property (@(posedge clk) disable iff (!reset) !(push && q_cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: scenario tasks against a transaction-level model (array + expected-response queue).
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int LATENCY   = 2;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 4096;

    typedef struct packed {
        logic        w;
        logic        e;
        logic [15:0] d;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus();
    mem_responder #(.LATENCY(LATENCY), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int outstanding = 0;
    logic [15:0] model_mem [MEM_WORDS];
    rec_t exp_q[$];
    rec_t obs_q[$];
    int   acc_cyc[$];
    int   obs_cyc[$];

    function automatic logic rsp_err_now();
`ifdef MEM_RESPONDER_ERR_EN
        return bus.rsp_err;
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour of one accepted request.
    function automatic void model_accept(logic w, logic [15:0] a, logic [15:0] wd);
        rec_t r;
        logic oor;
        oor = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
        oor = (int'(a) >= MEM_WORDS);
`endif
        r.w = w;
        r.e = oor;
        if (w) begin
            r.d = wd;
            if (!oor) model_mem[int'(a) % MEM_WORDS] = wd;
        end else begin
            r.d = oor ? 16'h0000 : model_mem[int'(a) % MEM_WORDS];
        end
        exp_q.push_back(r);
        acc_cyc.push_back(edge_n);
    endfunction

    function automatic void clear_logs();
        exp_q.delete(); obs_q.delete(); acc_cyc.delete(); obs_cyc.delete();
    endfunction

    // One clock: observe handshakes just before the edge, update model after it.
    task automatic tick();
        logic acc, pop, w;
        logic [15:0] a, wd;
        rec_t r;
        acc = bus.req_valid && bus.req_ready;
        pop = bus.rsp_valid && bus.rsp_ready;
        w = bus.req_write; a = bus.req_addr; wd = bus.req_wdata;
        r = '{bus.rsp_write, rsp_err_now(), bus.rsp_rdata};
        @(posedge clk);
        edge_n++;
        if (acc) begin model_accept(w, a, wd); outstanding++; end
        if (pop) begin obs_q.push_back(r); obs_cyc.push_back(edge_n); outstanding--; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.busy, bus.rsp_rdata} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b vld=%b wr=%b busy=%b rdata=%h want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.busy, bus.rsp_rdata);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre_edge got %b want 0", bus.req_ready); end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_post_edge got %b want 1", bus.req_ready); end
        clear_logs();
        outstanding = 0;
    endtask

    task automatic test_fill();
        int k;
        k = 0;
        clear_logs();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 64 && k < 200; k++) begin
            logic acc;
            bus.req_valid = 1'b1; bus.req_write = 1'b1;
            bus.req_addr = 16'(i); bus.req_wdata = 16'($urandom);
            acc = bus.req_ready;
            tick();
            if (acc) i++;
        end
        bus.req_valid = 1'b0;
        for (int j = 0; j < 40 && obs_q.size() < exp_q.size(); j++) tick();
        n_checks++;
        if (obs_q.size() != 64 || exp_q.size() != 64) begin
            n_fail++; $display("FAIL fill_count got %0d/%0d want 64", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_store_load();
        clear_logs();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h0010; bus.req_wdata = 16'hBEEF;
        tick();
        bus.req_write = 1'b0; bus.req_wdata = 16'h0000;
        tick();
        bus.req_valid = 1'b0;
        for (int j = 0; j < 20 && obs_q.size() < exp_q.size(); j++) tick();
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL sl_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            n_checks++;
            if (obs_q[0] !== rec_t'({1'b1, 1'b0, 16'hBEEF})) begin n_fail++; $display("FAIL sl_store got %h want 1/0/beef", obs_q[0]); end
            n_checks++;
            if (obs_q[1] !== rec_t'({1'b0, 1'b0, 16'hBEEF})) begin n_fail++; $display("FAIL sl_load got %h want 0/0/beef", obs_q[1]); end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_cyc[i] - acc_cyc[i] != LATENCY + 1) begin
                    n_fail++; $display("FAIL sl_latency[%0d] got %0d want %0d", i, obs_cyc[i] - acc_cyc[i], LATENCY + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bus.req_valid = (exp_q.size() < 6); bus.req_write = 1'b0;
            bus.req_addr = 16'(16'h20 + exp_q.size());
            tick();
        end
        n_checks++;
        if (exp_q.size() != DEPTH) begin n_fail++; $display("FAIL bp_accepted got %0d want %0d", exp_q.size(), DEPTH); end
        n_checks++;
        if ({bus.req_ready, bus.busy, bus.rsp_valid} !== 3'b011) begin
            n_fail++; $display("FAIL bp_full_state got rdy/busy/vld=%b%b%b want 011", bus.req_ready, bus.busy, bus.rsp_valid);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 20 && obs_q.size() < exp_q.size(); j++) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            n_fail++; $display("FAIL bp_drained got rdy/busy=%b%b want 10", bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        rec_t prev, cur;
        logic held;
        int issued;
        pat = 4'b1001; held = 1'b0; issued = 0; prev = '0;
        clear_logs();
        for (int k = 0; k < 100 && (issued < 8 || obs_q.size() < exp_q.size()); k++) begin
            bus.rsp_ready = pat[k % 4];
            bus.req_valid = (issued < 8); bus.req_write = 1'b0;
            bus.req_addr = 16'($urandom_range(0, 63));
            cur = '{bus.rsp_write, rsp_err_now(), bus.rsp_rdata};
            if (held) begin
                n_checks++;
                if (cur !== prev) begin n_fail++; $display("FAIL stall_hold got %h want %h", cur, prev); end
            end
            held = bus.rsp_valid && !bus.rsp_ready;
            prev = cur;
            if (bus.req_valid && bus.req_ready) issued++;
            tick();
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        n_checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            n_fail++; $display("FAIL stall_count got %0d/%0d want 8", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int n;
        v = 16'($urandom); n = 0;
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            bus.req_valid = 1'b1; bus.req_write = (n == 0);
            bus.req_addr = (n == 1) ? 16'h0031 : 16'h0030; bus.req_wdata = v;
            if (bus.req_ready) n++;
            tick();
        end
        bus.req_valid = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_write, bus.rsp_rdata} !== 20'h0) begin
            n_fail++; $display("FAIL midreset_outputs got vld=%b busy=%b rdy=%b wr=%b rdata=%h want all 0",
                               bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_write, bus.rsp_rdata);
        end
        clear_logs();
        outstanding = 0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0030;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL midreset_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_checks++;
            if (obs_q[0] !== rec_t'({1'b0, 1'b0, v})) begin n_fail++; $display("FAIL midreset_load got %h want 0/0/%h", obs_q[0], v); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] prior;
        prior = model_mem[5];
        clear_logs();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h1005; bus.req_wdata = 16'h1234;
        tick();
        bus.req_write = 1'b0; bus.req_addr = 16'h0005;
        tick();
        bus.req_valid = 1'b0;
        for (int j = 0; j < 20 && obs_q.size() < exp_q.size(); j++) tick();
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
`ifdef MEM_RESPONDER_ERR_EN
            n_checks++;
            if (obs_q[0] !== rec_t'({1'b1, 1'b1, 16'h1234})) begin n_fail++; $display("FAIL wrap_err_store got %h want 1/1/1234", obs_q[0]); end
            n_checks++;
            if (obs_q[1] !== rec_t'({1'b0, 1'b0, prior})) begin n_fail++; $display("FAIL wrap_err_load got %h want 0/0/%h", obs_q[1], prior); end
`else
            n_checks++;
            if (obs_q[1] !== rec_t'({1'b0, 1'b0, 16'h1234})) begin n_fail++; $display("FAIL wrap_load got %h want 0/0/1234 (prior %h)", obs_q[1], prior); end
`endif
        end
    endtask

    task automatic test_stream();
        clear_logs();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.req_valid = 1'b1; bus.req_write = (i % 2 == 0);
            bus.req_addr = 16'($urandom_range(0, 63)); bus.req_wdata = 16'($urandom);
            n_checks++;
            if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", i, bus.req_ready); end
            tick();
        end
        bus.req_valid = 1'b0;
        for (int j = 0; j < 20 && obs_q.size() < exp_q.size(); j++) tick();
        n_checks++;
        if (obs_q.size() != 20) begin n_fail++; $display("FAIL stream_count got %0d want 20", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 20) begin
            n_checks++;
            if (obs_cyc[0] - acc_cyc[0] != LATENCY + 1) begin
                n_fail++; $display("FAIL stream_first_latency got %0d want %0d", obs_cyc[0] - acc_cyc[0], LATENCY + 1);
            end
            n_checks++;
            if (obs_cyc[19] - obs_cyc[0] != 19) begin
                n_fail++; $display("FAIL stream_cadence got span %0d want 19", obs_cyc[19] - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        clear_logs();
        for (int k = 0; k < 400; k++) begin
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 16'h1000;
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.req_write = $urandom_range(0, 1) == 1;
            bus.req_addr  = a;
            bus.req_wdata = 16'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            n_checks++;
            if (bus.req_ready !== (outstanding < DEPTH)) begin
                n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", k, bus.req_ready, outstanding < DEPTH);
            end
            n_checks++;
            if (bus.busy !== (outstanding != 0)) begin
                n_fail++; $display("FAIL rand_busy cyc %0d got %b want %b", k, bus.busy, outstanding != 0);
            end
            tick();
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        for (int j = 0; j < 40 && obs_q.size() < exp_q.size(); j++) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.rsp_ready = 1'b0;
        test_reset();
        test_fill();
        test_store_load();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
